// File: rtl/scan_ctrl_pkg.sv
// Shared state encoding and counter sizing for the scan chain controller.
package scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CAPT  = 2'd2,
        ST_FLUSH = 2'd3
    } scan_state_e;

    localparam int CHAIN_LEN_DFLT = 32;

    // The down-counter is loaded with the chain length itself, hence the +1.
    function automatic int cnt_width(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

    localparam int CNT_W = cnt_width(CHAIN_LEN_DFLT);

endpackage

// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: serialises test patterns into a scan chain, pulses one
// functional capture, and unloads the captured response while the next pattern
// (or a flush of zeros) is shifted in.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | scan_se low; accept a pattern or start a pending flush
// ST_SHIFT | scan_se high for CHAIN_LEN cycles, pattern MSB first on scan_si
// ST_CAPT  | single scan_se low cycle, chain captures functional response
// ST_FLUSH | like ST_SHIFT with scan_si=0, unloads the last capture of a burst
module scan_chain_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 32
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rstn,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic [CHAIN_LEN-1:0] pat_data,
    input  logic                 pat_last,
    output logic                 scan_se,
    output logic                 scan_si,
    input  logic                 scan_so,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [CHAIN_LEN-1:0] rsp_data,
    output logic                 busy
);

    localparam int             CNT_WL   = cnt_width(CHAIN_LEN);
    localparam logic [CNT_WL-1:0] CNT_LOAD = CNT_WL'(CHAIN_LEN);
    localparam logic [CNT_WL-1:0] CNT_ONE  = CNT_WL'(1);

    scan_state_e          state_q, state_d;
    logic [CNT_WL-1:0]    cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] pat_sr_q, pat_sr_d;
    logic [CHAIN_LEN-1:0] ul_q, ul_d;
    logic [CHAIN_LEN-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 scan_se_q, scan_se_d;
    logic                 scan_si_q, scan_si_d;
    logic                 cap_pend_q, cap_pend_d;
    logic                 flush_pend_q, flush_pend_d;
    logic                 ul_vld_q, ul_vld_d;
    logic                 last_q, last_d;

    logic [CHAIN_LEN-1:0] so_ext;
    logic [CHAIN_LEN-1:0] ul_shift;
    logic                 slot_free;
    logic                 pat_ready_c;

    // The response slot counts as free when it is empty or being drained this cycle.
    assign slot_free   = !rsp_valid_q || rsp_ready;
    assign pat_ready_c = (state_q == ST_IDLE) && !flush_pend_q && slot_free;

    // Next-state logic for the sequencer, unload register and response slot.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pat_sr_d     = pat_sr_q;
        ul_d         = ul_q;
        rsp_data_d   = rsp_data_q;
        rsp_valid_d  = rsp_valid_q;
        scan_se_d    = scan_se_q;
        scan_si_d    = scan_si_q;
        cap_pend_d   = cap_pend_q;
        flush_pend_d = flush_pend_q;
        ul_vld_d     = ul_vld_q;
        last_d       = last_q;

        so_ext    = '0;
        so_ext[0] = scan_so;
        ul_shift  = (ul_q << 1) | so_ext;

        if (scan_se_q) begin
            ul_d = ul_shift;
        end
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (flush_pend_q && slot_free) begin
                    state_d    = ST_FLUSH;
                    scan_se_d  = 1'b1;
                    scan_si_d  = 1'b0;
                    cnt_d      = CNT_LOAD;
                    ul_vld_d   = cap_pend_q;
                    cap_pend_d = 1'b0;
                end else if (pat_valid && pat_ready_c) begin
                    state_d    = ST_SHIFT;
                    scan_se_d  = 1'b1;
                    scan_si_d  = pat_data[CHAIN_LEN-1];
                    pat_sr_d   = pat_data << 1;
                    cnt_d      = CNT_LOAD;
                    ul_vld_d   = cap_pend_q;
                    cap_pend_d = 1'b0;
                    last_d     = pat_last;
                end
            end
            ST_SHIFT, ST_FLUSH: begin
                cnt_d     = cnt_q - CNT_ONE;
                pat_sr_d  = pat_sr_q << 1;
                scan_si_d = (state_q == ST_SHIFT) ? pat_sr_q[CHAIN_LEN-1] : 1'b0;
                if (cnt_q == CNT_ONE) begin
                    scan_se_d = 1'b0;
                    scan_si_d = 1'b0;
                    ul_vld_d  = 1'b0;
                    // A new response takes priority over retiring the old one.
                    if (ul_vld_q) begin
                        rsp_data_d  = ul_shift;
                        rsp_valid_d = 1'b1;
                    end
                    if (state_q == ST_SHIFT) begin
                        state_d = ST_CAPT;
                    end else begin
                        state_d      = ST_IDLE;
                        flush_pend_d = 1'b0;
                    end
                end
            end
            ST_CAPT: begin
                cap_pend_d = 1'b1;
                if (last_q) begin
                    flush_pend_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register all state and outputs; reset discards any in-flight operation.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            pat_sr_q     <= '0;
            ul_q         <= '0;
            rsp_data_q   <= '0;
            rsp_valid_q  <= 1'b0;
            scan_se_q    <= 1'b0;
            scan_si_q    <= 1'b0;
            cap_pend_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            ul_vld_q     <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pat_sr_q     <= pat_sr_d;
            ul_q         <= ul_d;
            rsp_data_q   <= rsp_data_d;
            rsp_valid_q  <= rsp_valid_d;
            scan_se_q    <= scan_se_d;
            scan_si_q    <= scan_si_d;
            cap_pend_q   <= cap_pend_d;
            flush_pend_q <= flush_pend_d;
            ul_vld_q     <= ul_vld_d;
            last_q       <= last_d;
        end
    end

    assign pat_ready = pat_ready_c;
    assign scan_se   = scan_se_q;
    assign scan_si   = scan_si_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/scan_chain_ctrl.md
SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 Parameter CHAIN_LEN, 32, scan-chain length in flops (legal 1..64).
REQ-002 nvdla_core_clk  in  1  single clock; all state updates on rising edge.
REQ-003 nvdla_core_rstn  in  1  reset, asynchronous assert, active-low.
REQ-004 pat_valid  in  1  pattern offered.
REQ-005 pat_ready  out  1  pattern accepted when pat_valid && pat_ready.
REQ-006 pat_data  in  CHAIN_LEN  pattern; bit i lands in chain flop i (0 = head, nearest SI).
REQ-007 pat_last  in  1  last pattern of a burst; requests a flush unload after its capture.
REQ-008 scan_se  out  1  scan enable to chain; 1 = shift, 0 = functional capture.
REQ-009 scan_si  out  1  serial data into chain head.
REQ-010 scan_so  in  1  serial data from chain tail (flop CHAIN_LEN-1).
REQ-011 rsp_valid  out  1  captured response available.
REQ-012 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-013 rsp_data  out  CHAIN_LEN  captured response; bit i = value captured in flop i.
REQ-014 busy  out  1  high whenever state != IDLE.

Function
REQ-015 FSM states: IDLE, SHIFT, CAPT, FLUSH.
REQ-016 scan_se, scan_si SHALL be driven directly from flops (no combinational path from any input).
REQ-017 IDLE: scan_se=0; pat_ready=1 only when flush_pend=0 and response slot free (!rsp_valid || rsp_ready).
REQ-018 Priority in IDLE: flush_pend && slot free -> FLUSH; else accepted pattern -> SHIFT.
REQ-019 SHIFT: scan_se=1 for exactly CHAIN_LEN consecutive cycles; scan_si carries pat_data MSB first (pat_data[CHAIN_LEN-1] in first cycle, pat_data[0] in last).
REQ-020 FLUSH: identical to SHIFT with scan_si=0; clears flush_pend on exit; exits to IDLE.
REQ-021 Every rising edge with scan_se=1 SHALL sample scan_so into the unload register: ul <= {ul[CHAIN_LEN-2:0], scan_so}.
REQ-022 SHIFT exits to CAPT: one cycle scan_se=0, sets cap_pend; pat_last of that pattern sets flush_pend; then IDLE.
REQ-023 cap_pend is cleared at the start of each SHIFT/FLUSH; that operation is marked unload-valid if cap_pend was set.
REQ-024 After the CHAIN_LEN-th sample edge of an unload-valid operation: rsp_data <= ul, rsp_valid <= 1, held stable until handshake.
REQ-025 Unload with no prior capture SHALL produce no response.
REQ-026 Timing: pattern accepted at edge E -> scan_se=1 cycles E+1..E+CHAIN_LEN, capture cycle E+CHAIN_LEN+1, pat_ready may reassert in cycle E+CHAIN_LEN+2; throughput CHAIN_LEN+2 cycles/pattern.
REQ-027 rsp_ready asserted in the same cycle a new response is loaded: old response retires, new one takes its place, no loss.
REQ-028 CHAIN_LEN=1: ul is a single flop; all above timing holds with N=1.

Reset
REQ-029 Reset asserted: state=IDLE, scan_se=0, scan_si=0, rsp_valid=0, rsp_data=0, busy=0, cap_pend=0, flush_pend=0, counter=0, immediately (asynchronous).
REQ-030 Reset mid-operation SHALL discard in-flight pattern and unload data; first post-reset shift is not unload-valid.
REQ-031 pat_ready=1 in first cycle after reset release.

Structure
REQ-032 Shared package scan_ctrl_pkg holds the state enum and the counter-width constant CNT_W = clog2(CHAIN_LEN+1).
REQ-033 Single module, no sub-modules; pattern shift register, unload register, counter and FSM inline.

Verification (CHAIN_LEN=8, chain model of 8 scan flops, functional D = ~Q)
REQ-034 Reset pulse mid-run -> all outputs 0 asynchronously; pat_ready=1 first cycle after release.
REQ-035 Pattern 0xA5, pat_last=1 -> scan_si 1,0,1,0,0,1,0,1 over 8 se=1 cycles, 1 capture cycle, no rsp after SHIFT, FLUSH then rsp_data=0x5A.
REQ-036 Back-to-back 0x0F then 0xF0 (last) -> responses 0xF0, 0x0F in order; second pattern accepted 10 cycles after first.
REQ-037 rsp_ready held 0 with response pending -> pat_ready=0, scan_se stays 0, rsp_data stable; release -> next shift starts next cycle.
REQ-038 Reset at 4th SHIFT cycle, then pattern 0x3C (last) -> only one response, 0xC3; no spurious response.
REQ-039 CHAIN_LEN=1, patterns 1 then 0 (last) -> responses 0 then 1; se high 1 cycle per shift.
